fetch_unit: RTL and testbench

- Instruction fetch front end for the 16-bit, 5-bit-opcode processor.
- Owns the PC and issues read requests to instruction memory.
- Presents each fetched instruction as instr[15:0] and opcode[4:0] to the control decoder and datapath; holds it while the consumer stalls.
- Applies branch/jump redirects at consume time; stops fetching on HALT.

---
 rtl/fetch_unit.sv | 190 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : fetch_unit
// Description : Instruction fetch front end for the 16-bit, 5-bit-opcode
//               processor. Owns the PC, issues reads to instruction memory,
//               holds the fetched instruction until the consumer takes it,
//               applies branch/jump redirects at consume time and stops
//               fetching once a HALT instruction is consumed.
//               Optional macro FETCH_ALIGN_CHECK_EN: a consumed redirect to an
//               odd address raises a sticky align_err and halts fetch instead
//               of silently clearing the target's low bit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [4:0]  HALT_OPC  = 5'b00000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr,
    output logic [4:0]  opcode,
    output logic        instr_valid,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2,
    output logic        halted,
    output logic        align_err
);

    // Fetch controller states.
    localparam logic [1:0] c_FETCH  = 2'd0;
    localparam logic [1:0] c_ISSUE  = 2'd1;
    localparam logic [1:0] c_HALTED = 2'd2;

    localparam logic [15:0] c_PC_STEP = 16'h0002;

    // Architectural state.
    logic [1:0]  r_state;
    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_pc_out;
    logic        r_valid;
    logic        r_halted;

    // Next-state values.
    logic [1:0]  w_state_nxt;
    logic [15:0] w_pc_nxt;
    logic [15:0] w_instr_nxt;
    logic [15:0] w_pc_out_nxt;
    logic        w_valid_nxt;
    logic        w_halted_nxt;

    // Decoded events of the current cycle.
    logic        w_handshake;
    logic        w_consume;
    logic        w_is_halt;
    logic [15:0] w_redirect_tgt;
    logic        w_redirect_bad;
    logic        w_align_set;

    // A memory handshake only counts while we are actually requesting.
    assign w_handshake = imem_req & imem_ready;
    assign w_consume   = (r_state == c_ISSUE) & ~stall;
    assign w_is_halt   = (r_instr[15:11] == HALT_OPC);

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_align_err;

    // Odd targets are trapped rather than fetched.
    assign w_redirect_tgt = redirect_pc;
    assign w_redirect_bad = redirect_pc[0];
    assign align_err      = r_align_err;

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_align_err <= 1'b0;
        end else if (w_align_set) begin
            r_align_err <= 1'b1;
        end
    end
`else
    // Without the check, instructions are halfword aligned by construction:
    // the low bit of a redirect target is simply dropped.
    assign w_redirect_tgt = redirect_pc & 16'hFFFE;
    assign w_redirect_bad = 1'b0;
    assign align_err      = 1'b0;
`endif

    // HALT takes precedence over redirect, so a trap is only raised by a
    // consumed, non-HALT instruction that carries a redirect.
    assign w_align_set = w_consume & ~w_is_halt & redirect & w_redirect_bad;

    // Next-state and datapath selection for the fetch controller.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_pc_out_nxt = r_pc_out;
        w_valid_nxt  = r_valid;
        w_halted_nxt = r_halted;

        case (r_state)
            c_FETCH: begin
                // Address stays on r_pc until the memory accepts it.
                if (w_handshake) begin
                    w_instr_nxt  = imem_rdata;
                    w_pc_out_nxt = r_pc;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = c_ISSUE;
                end
            end

            c_ISSUE: begin
                // While stalled everything holds and any redirect is dropped.
                if (w_consume) begin
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = NOP_INSTR;
                    if (w_is_halt) begin
                        // PC intentionally left at the HALT's address.
                        w_halted_nxt = 1'b1;
                        w_state_nxt  = c_HALTED;
                    end else if (redirect && w_redirect_bad) begin
                        w_halted_nxt = 1'b1;
                        w_state_nxt  = c_HALTED;
                    end else if (redirect) begin
                        w_pc_nxt    = w_redirect_tgt;
                        w_state_nxt = c_FETCH;
                    end else begin
                        w_pc_nxt    = r_pc + c_PC_STEP;
                        w_state_nxt = c_FETCH;
                    end
                end
            end

            c_HALTED: begin
                // Terminal until reset.
                w_valid_nxt  = 1'b0;
                w_halted_nxt = 1'b1;
            end

            default: begin
                // Unreachable encoding: recover into a clean fetch.
                w_state_nxt = c_FETCH;
                w_valid_nxt = 1'b0;
                w_instr_nxt = NOP_INSTR;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_FETCH;
            r_pc     <= RESET_PC;
            r_instr  <= NOP_INSTR;
            r_pc_out <= RESET_PC;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_pc_out <= w_pc_out_nxt;
            r_valid  <= w_valid_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Request is masked by reset so a pending fetch is dropped immediately.
    assign imem_req    = (r_state == c_FETCH) & ~rst;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[15:11];
    assign instr_valid = r_valid;
    assign pc_out      = r_pc_out;
    assign pc_plus2    = r_pc_out + c_PC_STEP;
    assign halted      = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. Honours the
//               FETCH_ALIGN_CHECK_EN macro for the odd-redirect case.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr;
    logic [4:0]  opcode;
    logic        instr_valid;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2;
    logic        halted;
    logic        align_err;

    int n_checks;
    int n_fail;

    logic [15:0] mem [0:32767];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .pc_plus2    (pc_plus2),
        .halted      (halted),
        .align_err   (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory model, halfword addressed.
    assign imem_rdata = mem[imem_addr[15:1]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0800;
        mem[16'h0000 >> 1] = 16'h4000;
        mem[16'h0002 >> 1] = 16'h4801;
        mem[16'h0004 >> 1] = 16'hC803;
        mem[16'h0006 >> 1] = 16'h1000;
        mem[16'h0040 >> 1] = 16'h2000;
        mem[16'hFFFE >> 1] = 16'h3000;
        mem[16'h0020 >> 1] = 16'h0000;   // HALT

        rst         = 1'b1;
        imem_ready  = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;

        // Reset state
        tick();
        tick();
        check_eq("rst_req",    {31'd0, imem_req},    32'd0);
        check_eq("rst_instr",  {16'd0, instr},       32'h0800);
        check_eq("rst_valid",  {31'd0, instr_valid}, 32'd0);
        check_eq("rst_halted", {31'd0, halted},      32'd0);
        check_eq("rst_align",  {31'd0, align_err},   32'd0);

        // Back-to-back fetch, ready always high
        rst = 1'b0;
        #1;
        check_eq("f0_req",  {31'd0, imem_req}, 32'd1);
        check_eq("f0_addr", {16'd0, imem_addr}, 32'h0000);
        tick();
        check_eq("i0_valid",  {31'd0, instr_valid}, 32'd1);
        check_eq("i0_instr",  {16'd0, instr},       32'h4000);
        check_eq("i0_pc",     {16'd0, pc_out},      32'h0000);
        check_eq("i0_opc",    {27'd0, opcode},      32'h08);
        check_eq("i0_pcp2",   {16'd0, pc_plus2},    32'h0002);
        check_eq("i0_req",    {31'd0, imem_req},    32'd0);
        tick();
        check_eq("f1_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("f1_instr", {16'd0, instr},       32'h0800);
        check_eq("f1_addr",  {16'd0, imem_addr},   32'h0002);
        tick();
        check_eq("i1_instr", {16'd0, instr},  32'h4801);
        check_eq("i1_pc",    {16'd0, pc_out}, 32'h0002);
        check_eq("i1_opc",   {27'd0, opcode}, 32'h09);

        // Memory not ready for 3 cycles at 0x0004
        imem_ready = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            check_eq("wait_req",   {31'd0, imem_req},    32'd1);
            check_eq("wait_addr",  {16'd0, imem_addr},   32'h0004);
            check_eq("wait_valid", {31'd0, instr_valid}, 32'd0);
            tick();
        end
        imem_ready = 1'b1;
        check_eq("wait_req4",  {31'd0, imem_req},  32'd1);
        check_eq("wait_addr4", {16'd0, imem_addr}, 32'h0004);
        tick();
        check_eq("i2_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("i2_instr", {16'd0, instr},       32'hC803);

        // Stall with redirect: redirect is discarded
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("stall_instr", {16'd0, instr},       32'hC803);
            check_eq("stall_pc",    {16'd0, pc_out},      32'h0004);
            check_eq("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        stall    = 1'b0;
        redirect = 1'b0;
        tick();
        check_eq("post_stall_addr", {16'd0, imem_addr}, 32'h0006);
        tick();

        // Consumed redirect
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        check_eq("redir_addr", {16'd0, imem_addr}, 32'h0040);
        redirect = 1'b0;
        tick();
        check_eq("redir_instr", {16'd0, instr}, 32'h2000);

        // PC wrap at 0xFFFE
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        tick();
        check_eq("wrap_pc",   {16'd0, pc_out},   32'hFFFE);
        check_eq("wrap_pcp2", {16'd0, pc_plus2}, 32'h0000);
        tick();
        check_eq("wrap_addr", {16'd0, imem_addr}, 32'h0000);
        tick();

        // Odd redirect target
        redirect    = 1'b1;
        redirect_pc = 16'h0021;
        tick();
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("odd_align",  {31'd0, align_err}, 32'd1);
        check_eq("odd_halted", {31'd0, halted},    32'd1);
        check_eq("odd_req",    {31'd0, imem_req},  32'd0);
        tick();
        check_eq("odd_sticky", {31'd0, align_err}, 32'd1);
`else
        check_eq("odd_addr",  {16'd0, imem_addr}, 32'h0020);
        check_eq("odd_align", {31'd0, align_err}, 32'd0);
`endif

        // Reset, then reach HALT at 0x0020 with a redirect asserted
        rst = 1'b1;
        tick();
        check_eq("rst2_req",   {31'd0, imem_req},  32'd0);
        check_eq("rst2_align", {31'd0, align_err}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rst2_addr", {16'd0, imem_addr}, 32'h0000);
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        redirect = 1'b0;
        tick();
        check_eq("halt_instr", {16'd0, instr}, 32'h0000);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        check_eq("halt_halted", {31'd0, halted},      32'd1);
        check_eq("halt_valid",  {31'd0, instr_valid}, 32'd0);
        check_eq("halt_instr2", {16'd0, instr},       32'h0800);
        for (int k = 0; k < 10; k++) begin
            check_eq("halt_req", {31'd0, imem_req}, 32'd0);
            tick();
        end
        check_eq("halt_stay", {31'd0, halted}, 32'd1);

        // Reset releases HALTED
        rst = 1'b1;
        tick();
        check_eq("rst3_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rst3_req1",   {31'd0, imem_req},  32'd1);
        check_eq("rst3_addr",   {16'd0, imem_addr}, 32'h0000);
        check_eq("rst3_halted", {31'd0, halted},    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
